// File: rtl/rs232_pkg.sv
// Shared types and line levels for the RS-232 transmit path.
package rs232_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, FIN} tx_state_t;

   localparam int   BITS_PER_CHAR = 8;
   localparam logic START_LVL     = 1'b0;
   localparam logic STOP_LVL      = 1'b1;
   localparam logic IDLE_LVL      = 1'b1;

endpackage

// File: rtl/rs232_baud_tick.sv
// Bit-period timer: pulses tick every CLKS_PER_BIT enabled cycles, held at zero while disabled.
module rs232_baud_tick #(
   parameter int CLKS_PER_BIT = 44
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt;

   assign tick = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             cnt <= '0;
      else if (!en || tick) cnt <= '0;
      else                  cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/rs232_tx_block.sv
// Serialises a NUM_BYTES block as back-to-back async frames, byte 0 first, LSB first.
// Define RS232_TX_PARITY_EN for 8E1 frames; otherwise 8N1.
module rs232_tx_block
   import rs232_pkg::*;
#(
   parameter int CLKS_PER_BIT = 44,
   parameter int NUM_BYTES    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [8*NUM_BYTES-1:0] data_in,
   input  logic                   tx_start,
   output logic                   tx_out,
   output logic                   busy,
   output logic                   done
);

   localparam int DW     = BITS_PER_CHAR * NUM_BYTES;
   localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   tx_state_t                state, state_nxt;
   logic [DW-1:0]            shreg;
   logic [2:0]               bit_cnt;
   logic [BYTE_W-1:0]        byte_cnt;
   logic [BITS_PER_CHAR-1:0] cur_byte;
   logic                     bit_tick, baud_en, last_byte;

   assign cur_byte  = shreg[BITS_PER_CHAR-1:0];
   assign last_byte = (byte_cnt == BYTE_W'(NUM_BYTES - 1));
   assign baud_en   = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

   rs232_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (baud_en),
      .tick (bit_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Outputs decode straight from state so an async reset drops the line high at once.
   always_comb begin
      state_nxt = state;
      tx_out    = IDLE_LVL;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (tx_start) state_nxt = START;
         end
         START: begin
            tx_out = START_LVL;
            if (bit_tick) state_nxt = DATA;
         end
         DATA: begin
            tx_out = cur_byte[bit_cnt];
`ifdef RS232_TX_PARITY_EN
            if (bit_tick && bit_cnt == 3'd7) state_nxt = PARITY;
`else
            if (bit_tick && bit_cnt == 3'd7) state_nxt = STOP;
`endif
         end
`ifdef RS232_TX_PARITY_EN
         PARITY: begin
            tx_out = ^cur_byte;
            if (bit_tick) state_nxt = STOP;
         end
`endif
         STOP: begin
            tx_out = STOP_LVL;
            if (bit_tick) state_nxt = last_byte ? FIN : START;
         end
         FIN: begin
            busy      = 1'b0;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // The current byte always sits in the low bits; each finished frame shifts the next one down.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (tx_start) begin
               shreg    <= data_in;
               bit_cnt  <= '0;
               byte_cnt <= '0;
            end
            START: if (bit_tick) bit_cnt <= '0;
            DATA:  if (bit_tick) bit_cnt <= bit_cnt + 3'd1;
            STOP:  if (bit_tick && !last_byte) begin
               byte_cnt <= byte_cnt + BYTE_W'(1);
               shreg    <= shreg >> BITS_PER_CHAR;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_tx_block.sv
// Scoreboard bench for rs232_tx_block: expected bytes queued at stimulus, checked as frames decode.
module tb_rs232_tx_block;

   localparam int CLKS = 44;
   localparam int NB   = 8;
`ifdef RS232_TX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif
   localparam int BLK = NB * FRAME * CLKS;
   localparam int TMO = 4 * FRAME * CLKS;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [63:0]   data_in = '0;
   logic          tx_start = 1'b0;
   logic          tx_out, busy, done;

   int            cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;
   logic [7:0]    exp_q[$];

   rs232_tx_block #(.CLKS_PER_BIT(CLKS), .NUM_BYTES(NB)) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .tx_start (tx_start),
      .tx_out   (tx_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus: queue the expected bytes, pulse tx_start, then scramble data_in.
   task automatic start_block(input logic [63:0] d);
      for (int k = 0; k < NB; k++) exp_q.push_back(d[8*k +: 8]);
      @(posedge clk); #1;
      data_in  = d;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      data_in  = {$urandom, $urandom};
   endtask

   // Line decoder: waits for a start edge, samples each bit mid-period.
   task automatic rx_byte(output logic [7:0] b, output logic st, output logic par,
                          output logic sp, output int fall, output bit ok);
      int n;
      b = '0; st = 1'b1; par = 1'b0; sp = 1'b0; fall = -1; ok = 1'b0; n = 0;
      do begin @(negedge clk); n++; end while (tx_out !== 1'b0 && n < TMO);
      if (tx_out !== 1'b0) return;
      fall = cyc;
      repeat (CLKS/2) @(negedge clk);
      st = tx_out;
      for (int i = 0; i < 8; i++) begin
         repeat (CLKS) @(negedge clk);
         b[i] = tx_out;
      end
`ifdef RS232_TX_PARITY_EN
      repeat (CLKS) @(negedge clk);
      par = tx_out;
`endif
      repeat (CLKS) @(negedge clk);
      sp = tx_out;
      ok = 1'b1;
   endtask

   task automatic wait_done(output int c, output logic bsy, output bit ok);
      int n;
      n = 0; c = -1; bsy = 1'bx; ok = 1'b0;
      do begin @(negedge clk); n++; end while (done !== 1'b1 && n < TMO);
      if (done !== 1'b1) return;
      c = cyc; bsy = busy; ok = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tx_start = ~tx_start;
         n_cmp++;
         if ({tx_out, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_hold[%0d]: tx_out/busy/done=%b expected 100", i, {tx_out, busy, done});
         end
      end
      tx_start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({tx_out, busy, done} !== 3'b100) begin
         n_err++;
         $display("FAIL reset_release: tx_out/busy/done=%b expected 100", {tx_out, busy, done});
      end
   endtask

   task automatic test_block(input logic [63:0] d, input string nm);
      logic [7:0] b, e;
      logic       st, par, sp, bsy;
      int         fall, first, dc;
      bit         ok;
      first = -1;
      start_block(d);
      n_cmp++;
      if ({tx_out, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL %s latency: tx_out/busy=%b expected 01", nm, {tx_out, busy});
      end
      for (int k = 0; k < NB; k++) begin
         rx_byte(b, st, par, sp, fall, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_cmp++;
         if (!ok || b !== e || st !== 1'b0 || sp !== 1'b1) begin
            n_err++;
            $display("FAIL %s byte%0d: got %h start=%b stop=%b ok=%0d expected %h start=0 stop=1",
                     nm, k, b, st, sp, ok, e);
         end
`ifdef RS232_TX_PARITY_EN
         n_cmp++;
         if (par !== ^e) begin
            n_err++;
            $display("FAIL %s parity%0d: got %b expected %b", nm, k, par, ^e);
         end
`endif
         if (k == 0) first = fall;
         else begin
            n_cmp++;
            if (fall !== first + k*FRAME*CLKS) begin
               n_err++;
               $display("FAIL %s frame_timing%0d: fall at %0d expected %0d", nm, k, fall, first + k*FRAME*CLKS);
            end
         end
      end
      wait_done(dc, bsy, ok);
      n_cmp++;
      if (!ok || dc !== first + BLK || bsy !== 1'b0) begin
         n_err++;
         $display("FAIL %s done_timing: done at %0d busy=%b expected %0d busy=0", nm, dc, bsy, first + BLK);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, busy, tx_out} !== 3'b001) begin
         n_err++;
         $display("FAIL %s post_fin: done/busy/tx_out=%b expected 001", nm, {done, busy, tx_out});
      end
   endtask

   task automatic test_busy_reject;
      logic [63:0] d;
      logic        bsy;
      int          dc, bad;
      bit          ok;
      d = 64'h5A3C_96E1_0F1E_2D4B;
      start_block(d);
      fork
         begin
            repeat (100) @(posedge clk); #1;
            data_in  = '1;
            tx_start = 1'b1;
            @(posedge clk); #1;
            tx_start = 1'b0;
         end
         begin
            logic [7:0] b, e;
            logic       st, par, sp;
            int         fall;
            bit         rok;
            for (int k = 0; k < NB; k++) begin
               rx_byte(b, st, par, sp, fall, rok);
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
               n_cmp++;
               if (!rok || b !== e || sp !== 1'b1) begin
                  n_err++;
                  $display("FAIL busy_reject byte%0d: got %h stop=%b ok=%0d expected %h", k, b, sp, rok, e);
               end
            end
         end
      join
      wait_done(dc, bsy, ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL busy_reject done: no done pulse expected one");
      end
      // Request during the FIN cycle must be dropped.
      data_in  = '1;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      bad = 0;
      repeat (3*FRAME*CLKS) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL busy_reject no_second_block: %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0] da, db;
      logic [7:0]  b, e;
      logic        st, par, sp, bsy;
      int          fall, dc, dc2, first;
      bit          ok;
      da = 64'hFEDC_BA98_7654_3210;
      db = 64'h0F0F_F0F0_3C3C_C3C3;
      first = -1;
      start_block(da);
      for (int k = 0; k < NB; k++) begin
         rx_byte(b, st, par, sp, fall, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_cmp++;
         if (!ok || b !== e) begin
            n_err++;
            $display("FAIL b2b blockA byte%0d: got %h expected %h", k, b, e);
         end
      end
      wait_done(dc, bsy, ok);
      @(posedge clk); #1;
      for (int k = 0; k < NB; k++) exp_q.push_back(db[8*k +: 8]);
      data_in  = db;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      for (int k = 0; k < NB; k++) begin
         rx_byte(b, st, par, sp, fall, ok);
         if (k == 0) first = fall;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_cmp++;
         if (!ok || b !== e || sp !== 1'b1) begin
            n_err++;
            $display("FAIL b2b blockB byte%0d: got %h stop=%b expected %h", k, b, sp, e);
         end
      end
      n_cmp++;
      if (!ok || first !== dc + 2) begin
         n_err++;
         $display("FAIL b2b gap: blockB start at %0d expected %0d", first, dc + 2);
      end
      wait_done(dc2, bsy, ok);
      n_cmp++;
      if (!ok || dc2 !== first + BLK) begin
         n_err++;
         $display("FAIL b2b blockB done: at %0d expected %0d", dc2, first + BLK);
      end
   endtask

   task automatic test_mid_reset;
      logic [63:0] d;
      logic [7:0]  b, e;
      logic        st, par, sp, bsy;
      int          fall, n, bad, dc, first;
      bit          ok;
      d = 64'hC0DE_CAFE_BEEF_F00D;
      first = -1;
      start_block(d);
      for (int k = 0; k < 3; k++) begin
         rx_byte(b, st, par, sp, fall, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_cmp++;
         if (!ok || b !== e) begin
            n_err++;
            $display("FAIL mid_reset byte%0d: got %h expected %h", k, b, e);
         end
      end
      n = 0;
      do begin @(negedge clk); n++; end while (tx_out !== 1'b0 && n < TMO);
      repeat (CLKS) @(negedge clk);
      // Byte 3 is 8'hBE: bit 0 is low, so the line is low right before reset.
      n_cmp++;
      if ({tx_out, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL mid_reset pre: tx_out/busy=%b expected 01", {tx_out, busy});
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({tx_out, busy, done} !== 3'b100) begin
         n_err++;
         $display("FAIL mid_reset async: tx_out/busy/done=%b expected 100", {tx_out, busy, done});
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      bad = 0;
      repeat (2*FRAME*CLKS) begin
         @(negedge clk);
         if (done !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL mid_reset quiet: %0d active cycles expected 0", bad);
      end
      d = 64'h1122_3344_5566_7788;
      start_block(d);
      for (int k = 0; k < NB; k++) begin
         rx_byte(b, st, par, sp, fall, ok);
         if (k == 0) first = fall;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_cmp++;
         if (!ok || b !== e || st !== 1'b0 || sp !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset resend byte%0d: got %h expected %h", k, b, e);
         end
      end
      wait_done(dc, bsy, ok);
      n_cmp++;
      if (!ok || dc !== first + BLK) begin
         n_err++;
         $display("FAIL mid_reset resend done: at %0d expected %0d", dc, first + BLK);
      end
   endtask

   initial begin
      test_reset();
      test_block(64'h0123_4567_89AB_CDEF, "single");
      test_block(64'h00FF_A55A_8001_0703, "pattern");
      test_busy_reject();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
